sound_request_scheduler: RTL and testbench



---
 rtl/sound_request_scheduler.sv | 148 ++++++++++++++
 tb/tb_sound_request_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sound_request_scheduler.sv
// Shares one tone generator among NUM_REQ event sources: latches request pulses,
// grants by fixed priority (index 0 highest), plays each tone for its duration, then a silent gap.
module sound_request_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int TICKS_PER_MS = 50000,
  parameter int GAP_MS       = 20
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*10-1:0]      tone_freq_in,
  input  logic [NUM_REQ*10-1:0]      dur_ms_in,
  output logic                       sound_enable,
  output logic [9:0]                 tone_freq,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = $clog2(TICKS_PER_MS + 1);
  localparam int GW   = $clog2(GAP_MS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [NUM_REQ-1:0]         pend_q, pend_d;
  logic [NUM_REQ-1:0][9:0]    freq_q, freq_d;
  logic [NUM_REQ-1:0][9:0]    dur_q, dur_d;
  logic [9:0]                 ms_cnt_q, ms_cnt_d;
  logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic                       sound_enable_q, sound_enable_d;
  logic [9:0]                 tone_freq_q, tone_freq_d;
  logic [ID_W-1:0]            active_id_q, active_id_d;
  logic                       busy_q, busy_d;

  logic            any_pend, preempt, tick, grant;
  logic [ID_W-1:0] g;

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    freq_d         = freq_q;
    dur_d          = dur_q;
    ms_cnt_d       = ms_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    sound_enable_d = sound_enable_q;
    tone_freq_d    = tone_freq_q;
    active_id_d    = active_id_q;
    busy_d         = busy_q;
    any_pend       = |pend_q;
    preempt        = 1'b0;
    grant          = 1'b0;
    g              = '0;
    tick           = (presc_q == PW'(TICKS_PER_MS - 1));
    presc_d        = tick ? '0 : presc_q + PW'(1);

    // Descending scan so the lowest pending index is the one left in g.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) g = i[ID_W-1:0];
      if (pend_q[i] && (i < int'(active_id_q))) preempt = 1'b1;
    end

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (any_pend) begin
          grant = 1'b1;
          if (dur_q[g] != 10'd0) begin
            ms_cnt_d       = dur_q[g];
            tone_freq_d    = freq_q[g];
            active_id_d    = g;
            sound_enable_d = 1'b1;
            busy_d         = 1'b1;
            state_d        = PLAY;
          end
        end
      end
      PLAY: begin
        if (tick && ms_cnt_q != 10'd0) ms_cnt_d = ms_cnt_q - 10'd1;
        if (preempt || (tick && ms_cnt_q <= 10'd1)) begin
          sound_enable_d = 1'b0;
          gap_cnt_d      = GW'(GAP_MS);
          presc_d        = '0;
          state_d        = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
          if (gap_cnt_q <= GW'(1)) begin
            busy_d  = 1'b0;
            presc_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh request beats the clear from its own grant in the same cycle.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        pend_d[i] = 1'b1;
        freq_d[i] = tone_freq_in[10*i +: 10];
        dur_d[i]  = dur_ms_in[10*i +: 10];
      end else if (grant && (g == i[ID_W-1:0])) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      pend_q         <= '0;
      freq_q         <= '0;
      dur_q          <= '0;
      ms_cnt_q       <= '0;
      gap_cnt_q      <= '0;
      presc_q        <= '0;
      sound_enable_q <= 1'b0;
      tone_freq_q    <= '0;
      active_id_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      freq_q         <= freq_d;
      dur_q          <= dur_d;
      ms_cnt_q       <= ms_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      presc_q        <= presc_d;
      sound_enable_q <= sound_enable_d;
      tone_freq_q    <= tone_freq_d;
      active_id_q    <= active_id_d;
      busy_q         <= busy_d;
    end
  end

  assign sound_enable = sound_enable_q;
  assign tone_freq    = tone_freq_q;
  assign active_id    = active_id_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Table-driven bench for sound_request_scheduler with TICKS_PER_MS=4, GAP_MS=2:
// one tone ms = 4 cycles, gap = 8 cycles.
module tb_sound_request_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic [3:0]  req;
  logic [39:0] tone_freq_in;
  logic [39:0] dur_ms_in;
  logic        sound_enable;
  logic [9:0]  tone_freq;
  logic [1:0]  active_id;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  sound_request_scheduler #(.NUM_REQ(4), .TICKS_PER_MS(4), .GAP_MS(2)) dut (
    .clk(clk), .resetN(resetN), .req(req), .tone_freq_in(tone_freq_in),
    .dur_ms_in(dur_ms_in), .sound_enable(sound_enable), .tone_freq(tone_freq),
    .active_id(active_id), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [39:0] freq;
    logic [39:0] dur;
    int          run;
    logic        se;
    logic        busy;
    logic [1:0]  id;
    logic [9:0]  tf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [39:0] pk(int s, logic [9:0] v);
    return 40'(v) << (10 * s);
  endfunction

  function automatic void add(logic [3:0] r, logic [39:0] f, logic [39:0] d, int n,
                              logic se, logic b, logic [1:0] id, logic [9:0] tf);
    vec_t v;
    v.req = r; v.freq = f; v.dur = d; v.run = n;
    v.se = se; v.busy = b; v.id = id; v.tf = tf;
    vecs.push_back(v);
  endfunction

  function automatic void hold(int n, logic se, logic b, logic [1:0] id, logic [9:0] tf);
    add(4'b0000, 40'd0, 40'd0, n, se, b, id, tf);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single request: 12 cycles of tone, 8 of gap.
    add(4'b0100, pk(2, 10'h155), pk(2, 10'd3), 1, 0, 0, 0, 10'h000);
    hold(12, 1, 1, 2, 10'h155);
    hold(8,  0, 1, 2, 10'h155);
    hold(2,  0, 0, 2, 10'h155);
    // Simultaneous requests: 1 then 3.
    add(4'b1010, pk(1, 10'h0AA) | pk(3, 10'h3C3), pk(1, 10'd1) | pk(3, 10'd1), 1, 0, 0, 2, 10'h155);
    hold(4, 1, 1, 1, 10'h0AA);
    hold(8, 0, 1, 1, 10'h0AA);
    hold(1, 0, 0, 1, 10'h0AA);
    hold(4, 1, 1, 3, 10'h3C3);
    hold(8, 0, 1, 3, 10'h3C3);
    hold(2, 0, 0, 3, 10'h3C3);
    // Preemption of source 2 by source 0 at its 5th playing cycle.
    add(4'b0100, pk(2, 10'h222), pk(2, 10'd10), 1, 0, 0, 3, 10'h3C3);
    hold(4, 1, 1, 2, 10'h222);
    add(4'b0001, pk(0, 10'h111), pk(0, 10'd1), 1, 1, 1, 2, 10'h222);
    hold(8, 0, 1, 2, 10'h222);
    hold(1, 0, 0, 2, 10'h222);
    hold(4, 1, 1, 0, 10'h111);
    hold(8, 0, 1, 0, 10'h111);
    hold(2, 0, 0, 0, 10'h111);
    // Lower priority source 3 waits for source 1 tone and gap.
    add(4'b0010, pk(1, 10'h101), pk(1, 10'd2), 1, 0, 0, 0, 10'h111);
    hold(3, 1, 1, 1, 10'h101);
    add(4'b1000, pk(3, 10'h303), pk(3, 10'd1), 5, 1, 1, 1, 10'h101);
    hold(8, 0, 1, 1, 10'h101);
    hold(1, 0, 0, 1, 10'h101);
    hold(4, 1, 1, 3, 10'h303);
    hold(8, 0, 1, 3, 10'h303);
    hold(2, 0, 0, 3, 10'h303);
    // Zero duration is dropped silently; a stuck pend[0] would block source 1 below.
    add(4'b0001, pk(0, 10'h0FF), pk(0, 10'd0), 4, 0, 0, 3, 10'h303);
    // Re-request in the grant cycle: source 1 plays twice, old data then new.
    add(4'b0010, pk(1, 10'h1A1), pk(1, 10'd1), 1, 0, 0, 3, 10'h303);
    add(4'b0010, pk(1, 10'h1B2), pk(1, 10'd1), 4, 1, 1, 1, 10'h1A1);
    hold(8, 0, 1, 1, 10'h1A1);
    hold(1, 0, 0, 1, 10'h1A1);
    hold(4, 1, 1, 1, 10'h1B2);
    hold(8, 0, 1, 1, 10'h1B2);
    hold(2, 0, 0, 1, 10'h1B2);
    // Overwrite: two source-2 requests during source 0 tone, only the last plays once.
    add(4'b0001, pk(0, 10'h0F0), pk(0, 10'd2), 1, 0, 0, 1, 10'h1B2);
    hold(2, 1, 1, 0, 10'h0F0);
    add(4'b0100, pk(2, 10'h010), pk(2, 10'd1), 2, 1, 1, 0, 10'h0F0);
    add(4'b0100, pk(2, 10'h020), pk(2, 10'd1), 4, 1, 1, 0, 10'h0F0);
    hold(8, 0, 1, 0, 10'h0F0);
    hold(1, 0, 0, 0, 10'h0F0);
    hold(4, 1, 1, 2, 10'h020);
    hold(8, 0, 1, 2, 10'h020);
    hold(3, 0, 0, 2, 10'h020);

    // Clock/reset
    resetN = 1'b0; req = '0; tone_freq_in = '0; dur_ms_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_se",    sound_enable, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_tf",    tone_freq, 0);
    chk("rst_id",    active_id, 0);
    chk("rst_state", state_dbg, 0);
    resetN = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      req          = vecs[r].req;
      tone_freq_in = vecs[r].freq;
      dur_ms_in    = vecs[r].dur;
      for (int k = 0; k < vecs[r].run; k++) begin
        @(negedge clk);
        req = '0;
        chk($sformatf("v%0d.%0d se", r, k),   sound_enable, vecs[r].se);
        chk($sformatf("v%0d.%0d busy", r, k), busy,         vecs[r].busy);
        chk($sformatf("v%0d.%0d id", r, k),   active_id,    vecs[r].id);
        chk($sformatf("v%0d.%0d tf", r, k),   tone_freq,    vecs[r].tf);
      end
    end

    // Reset mid-tone with source 2 pending behind source 0.
    req = 4'b0001; tone_freq_in = pk(0, 10'h2AB); dur_ms_in = pk(0, 10'd5);
    @(negedge clk);
    req = '0;
    for (int k = 0; k < 10 && !sound_enable; k++) @(negedge clk);
    chk("mid_play_started", sound_enable, 1);
    req = 4'b0100; tone_freq_in = pk(2, 10'h0CC); dur_ms_in = pk(2, 10'd1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("mid_play_tf", tone_freq, 10'h2AB);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_se",   sound_enable, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tf",   tone_freq, 0);
    chk("async_rst_id",   active_id, 0);
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d se", k),   sound_enable, 0);
      chk($sformatf("post_rst%0d busy", k), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
